barrier_lut_arbiter: RTL
========================

BARRIER_LUT_ARBITER -- requirements
Module: barrier_lut_arbiter

Interface
REQ-001 Parameters SHALL be, one per line, as name, default, meaning:
- NUM_REQ, 4, number of requesters sharing the barrier LUT lookup port.
- REQ_BITS, 2, log2(NUM_REQ).
- ACK_TIMEOUT, 15, maximum cycles in WAIT_ACK before abort.
REQ-002 Ports SHALL be, one per line, as name, direction, width, meaning:
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request; held until that requester's rsp_valid.
- req_comm_id  in  16*NUM_REQ  packed comm IDs; slice i belongs to requester i.
- req_state  in  3*NUM_REQ  packed barrier states.
- rsp_valid  out  NUM_REQ  one-cycle response pulse, one-hot.
- rsp_state  out  3  barrier state returned by the LUT.
- rsp_hit  out  1  LUT hit; qualified by rsp_valid.
- rsp_miss  out  1  LUT miss; qualified by rsp_valid.
- rsp_err  out  1  timeout abort; qualified by rsp_valid.
- comm_id  out  16  to LUT.
- barrier_state_in  out  3  to LUT.
- lookup_req  out  1  to LUT; level, registered.
- lookup_ack  in  1  from LUT; held high until lookup_req drops.
- barrier_state_out  in  3  from LUT.
- lut_hit  in  1  from LUT.
- lut_miss  in  1  from LUT.
- busy  out  1  high in any state other than IDLE.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT_ACK, RELEASE; all outputs SHALL be registered.
REQ-004 In IDLE with any req_valid bit set, the block SHALL grant one requester by round-robin: search starts at last_grant+1 modulo NUM_REQ, lowest index at or after that position wins.
REQ-005 On grant, the block SHALL latch the winner's index, comm_id and barrier state, assert lookup_req on the next cycle, and enter WAIT_ACK.
REQ-006 comm_id and barrier_state_in SHALL hold stable while lookup_req is high.
REQ-007 In WAIT_ACK, on lookup_ack=1 the block SHALL:
- capture barrier_state_out, lut_hit and lut_miss;
- on the next cycle, pulse rsp_valid[grant] for one cycle with the captured values on rsp_state, rsp_hit and rsp_miss, and rsp_err=0;
- deassert lookup_req;
- enter RELEASE.
REQ-008 If ACK_TIMEOUT cycles elapse in WAIT_ACK without lookup_ack, the block SHALL pulse rsp_valid[grant] with rsp_err=1, rsp_state=0, rsp_hit=0 and rsp_miss=0, deassert lookup_req, and enter RELEASE.
REQ-009 The timeout counter SHALL be 4 bits wide, clear on entry to WAIT_ACK, and saturate; it SHALL NOT wrap.
REQ-010 In RELEASE, the block SHALL stay until lookup_ack=0, then return to IDLE; no new grant is issued in the cycle lookup_ack is first seen low.
REQ-011 last_grant SHALL update only on grant.
REQ-012 Deassertion of req_valid by the granted requester after grant SHALL be ignored; the transaction completes and the response pulse is still issued.
REQ-013 Requests arriving during WAIT_ACK or RELEASE SHALL wait; the block SHALL have no queueing beyond the req_valid levels.
REQ-014 rsp_valid SHALL never have more than one bit set, and SHALL never fire for a requester that was not granted.
REQ-015 Minimum turnaround SHALL be one transaction per (LUT ack latency + 4) cycles.

Reset
REQ-016 Asserting reset (low), asynchronously and at any point including mid-transaction, SHALL force:
- state to IDLE;
- lookup_req, rsp_valid, rsp_hit, rsp_miss, rsp_err and busy to 0;
- comm_id, barrier_state_in, rsp_state and the timeout counter to 0;
- last_grant to NUM_REQ-1, so requester 0 has first priority.
REQ-017 A transaction in flight at reset SHALL produce no response after reset deasserts; the requester re-requests.

Structure
REQ-018 A shared barrier package SHALL hold COMM_ID_W=16, BSTATE_W=3 and the FSM state encoding (one-hot: IDLE=1, WAIT_ACK=2, RELEASE=4).
REQ-019 The round-robin search SHALL be a sub-module rr_priority_select (inputs: request vector, last_grant; outputs: grant index, any-grant flag).

Verification
REQ-020 The bench SHALL use a LUT model that raises ack 2 cycles after lookup_req and holds it until req drops, and SHALL cover these scenarios:
- req_valid=4'b0001, comm_id 0x00A5, state 3, model returns hit with state 3 -> rsp_valid=4'b0001, rsp_hit=1, rsp_state=3, then busy=0.
- req_valid=4'b1111 held, all hits -> grant order 0,1,2,3,0; each rsp_valid one-hot.
- Model never acks -> rsp_err=1 exactly 15 cycles after lookup_req rises; lookup_req=0 the next cycle.
- Model holds ack 5 extra cycles after req drops -> the block stays in RELEASE, and the next lookup_req rises only after ack falls.
- Reset asserted in WAIT_ACK -> all outputs 0 immediately, no rsp_valid after release, and the first grant after reset goes to requester 0.
- req_valid[2] dropped one cycle after its grant, model returns miss -> rsp_valid=4'b0100, rsp_miss=1.

Source files
------------

// File: rtl/barrier_lut_arbiter_pkg.sv
// Shared types and widths for the barrier LUT arbiter: field widths,
// one-hot FSM encoding and the saturating timeout increment.
package barrier_lut_arbiter_pkg;

  localparam int COMM_ID_W = 16;
  localparam int BSTATE_W  = 3;
  localparam int TMO_CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE     = 3'b001,
    WAIT_ACK = 3'b010,
    RELEASE  = 3'b100
  } state_t;

  // Holds at all-ones instead of wrapping back to zero.
  function automatic logic [TMO_CNT_W-1:0] sat_inc(input logic [TMO_CNT_W-1:0] value);
    return (value == '1) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/barrier_lut_arbiter_rr.sv
// Round-robin requester search: scans from last_grant+1 (mod NUM_REQ)
// upward and returns the first index whose request bit is set.
module rr_priority_select #(
  parameter int NUM_REQ  = 4,
  parameter int REQ_BITS = 2
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [REQ_BITS-1:0] last_grant,
  output logic [REQ_BITS-1:0] grant,
  output logic                any
);

  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    any   = 1'b0;
    // Offset NUM_REQ wraps back onto last_grant itself, so it has lowest priority.
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!any && req[REQ_BITS'(idx)]) begin
        grant = REQ_BITS'(idx);
        any   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/barrier_lut_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single barrier LUT lookup port with
// a level req/ack handshake, per-transaction timeout and one-hot responses.
module barrier_lut_arbiter
  import barrier_lut_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int REQ_BITS    = 2,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [COMM_ID_W*NUM_REQ-1:0]  req_comm_id,
  input  logic [BSTATE_W*NUM_REQ-1:0]   req_state,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [BSTATE_W-1:0]           rsp_state,
  output logic                          rsp_hit,
  output logic                          rsp_miss,
  output logic                          rsp_err,
  output logic [COMM_ID_W-1:0]          comm_id,
  output logic [BSTATE_W-1:0]           barrier_state_in,
  output logic                          lookup_req,
  input  logic                          lookup_ack,
  input  logic [BSTATE_W-1:0]           barrier_state_out,
  input  logic                          lut_hit,
  input  logic                          lut_miss,
  output logic                          busy
);

  // Last WAIT_ACK counter value before abort; clamped to the 4-bit counter range.
  localparam int TMO_LAST_I = (ACK_TIMEOUT < 1)  ? 0 :
                              (ACK_TIMEOUT > 16) ? 15 : ACK_TIMEOUT - 1;
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TMO_LAST_I);

  state_t                 state;
  logic [REQ_BITS-1:0]    last_grant;
  logic [REQ_BITS-1:0]    grant_idx;
  logic [TMO_CNT_W-1:0]   tmo_cnt;
  logic [REQ_BITS-1:0]    sel;
  logic                   sel_any;

  logic [COMM_ID_W-1:0]   comm_ids  [NUM_REQ];
  logic [BSTATE_W-1:0]    bstates   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign comm_ids[g] = req_comm_id[g*COMM_ID_W +: COMM_ID_W];
    assign bstates[g]  = req_state[g*BSTATE_W +: BSTATE_W];
  end

  rr_priority_select #(
    .NUM_REQ  (NUM_REQ),
    .REQ_BITS (REQ_BITS)
  ) u_rr (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (sel),
    .any        (sel_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= IDLE;
      last_grant       <= REQ_BITS'(NUM_REQ - 1);
      grant_idx        <= '0;
      tmo_cnt          <= '0;
      lookup_req       <= 1'b0;
      comm_id          <= '0;
      barrier_state_in <= '0;
      rsp_valid        <= '0;
      rsp_state        <= '0;
      rsp_hit          <= 1'b0;
      rsp_miss         <= 1'b0;
      rsp_err          <= 1'b0;
      busy             <= 1'b0;
    end else begin
      // Response fields are single-cycle pulses; default them low every cycle.
      rsp_valid <= '0;
      rsp_state <= '0;
      rsp_hit   <= 1'b0;
      rsp_miss  <= 1'b0;
      rsp_err   <= 1'b0;

      case (state)
        IDLE: begin
          if (sel_any) begin
            grant_idx        <= sel;
            last_grant       <= sel;
            comm_id          <= comm_ids[sel];
            barrier_state_in <= bstates[sel];
            lookup_req       <= 1'b1;
            tmo_cnt          <= '0;
            busy             <= 1'b1;
            state            <= WAIT_ACK;
          end
        end

        WAIT_ACK: begin
          // An ack arriving on the abort cycle still wins over the timeout.
          if (lookup_ack) begin
            rsp_valid  <= NUM_REQ'(1) << grant_idx;
            rsp_state  <= barrier_state_out;
            rsp_hit    <= lut_hit;
            rsp_miss   <= lut_miss;
            lookup_req <= 1'b0;
            state      <= RELEASE;
          end else if (tmo_cnt >= TMO_LAST) begin
            rsp_valid  <= NUM_REQ'(1) << grant_idx;
            rsp_err    <= 1'b1;
            lookup_req <= 1'b0;
            state      <= RELEASE;
          end else begin
            tmo_cnt <= sat_inc(tmo_cnt);
          end
        end

        RELEASE: begin
          // Return to IDLE only; the next grant is made from IDLE a cycle later.
          if (!lookup_ack) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          lookup_req <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
